// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Holds the controller state encoding, the minimum legal divisor,
// and the high-phase length rule H = ceil(N/2).
package clk_div_pkg;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUN     = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam int MIN_DIV = 2;

  // Number of high cycles in one output period of length n.
  function automatic int unsigned high_len(input int unsigned n);
    return (n >> 1) + (n & 32'd1);
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter and waveform generator for the divided clock.
// Registered outputs; wrap is a combinational flag from the current count.
// No backpressure: a new period starts at a stopped state or at wrap when restart=1.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] div,
  input  logic             active,
  input  logic             restart,
  output logic             clk_out,
  output logic             clk_en,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi;
  logic [CNT_W:0]   cnt_inc;

  assign hi      = CNT_W'(high_len(32'(div)));
  assign cnt_inc = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign wrap    = active && (cnt == div - CNT_W'(1));

  // Advance the period counter; restart or park at a period boundary.
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      clk_en  <= 1'b0;
    end else if (!active || wrap) begin
      cnt     <= '0;
      clk_out <= restart;
      clk_en  <= restart;
    end else begin
      cnt     <= cnt_inc[CNT_W-1:0];
      clk_out <= (cnt_inc < {1'b0, hi});
      clk_en  <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Glitch-free programmable clock divider: run/stop FSM plus divisor request handling.
// Registered outputs; requests ack one cycle after acceptance or at the next period wrap.
// Requests arriving while busy are dropped; the requester waits for busy=0.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             div_req,
  input  logic [CNT_W-1:0] div_val,
  output logic             div_ack,
  output logic             div_err,
  output logic             busy,
  output logic [CNT_W-1:0] cur_div,
  output logic             clk_out,
  output logic             clk_en
);

  localparam logic [CNT_W-1:0] MIN_N = CNT_W'(MIN_DIV);

  state_t           state;
  logic [CNT_W-1:0] pending;
  logic             wrap;
  logic             active;
  logic             restart;

  // A draining engine never starts another period at its wrap.
  assign active  = (state != STOPPED);
  assign restart = enable && (state != DRAIN);

  clk_div_core #(
    .CNT_W(CNT_W)
  ) u_core (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .div     (cur_div),
    .active  (active),
    .restart (restart),
    .clk_out (clk_out),
    .clk_en  (clk_en),
    .wrap    (wrap)
  );

  // Run/stop sequencing and divisor request acceptance, applied only at period boundaries.
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state   <= STOPPED;
      cur_div <= CNT_W'(DEFAULT_DIV);
      pending <= '0;
      busy    <= 1'b0;
      div_ack <= 1'b0;
      div_err <= 1'b0;
    end else begin
      div_ack <= 1'b0;
      div_err <= 1'b0;

      case (state)
        STOPPED: if (enable) state <= RUN;
        RUN:     if (!enable) state <= wrap ? STOPPED : DRAIN;
        DRAIN: begin
          if (wrap)        state <= STOPPED;
          else if (enable) state <= RUN;
        end
        default: state <= STOPPED;
      endcase

      // A pending divisor lands at a wrap, or immediately if the engine is parked
      // (covers a request accepted on the very edge the engine stopped).
      if (busy && (wrap || state == STOPPED)) begin
        cur_div <= pending;
        div_ack <= 1'b1;
        busy    <= 1'b0;
      end

      if (div_req && !busy) begin
        if (div_val < MIN_N) begin
          div_err <= 1'b1;
        end else if (state == STOPPED) begin
          cur_div <= div_val;
          div_ack <= 1'b1;
        end else begin
          pending <= div_val;
          busy    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Randomized bench for clk_div_ctrl against a period-position reference model.
// Inputs change 1 ns after each rising edge; outputs are compared at that point.
// Model tracks position within the period as an integer (-1 when stopped).
module tb_clk_div_ctrl;

  localparam int CNT_W = 8;
  localparam int DEF   = 2;

  logic             clk_in = 1'b0;
  logic             reset_n;
  logic             enable;
  logic             div_req;
  logic [CNT_W-1:0] div_val;
  logic             div_ack;
  logic             div_err;
  logic             busy;
  logic [CNT_W-1:0] cur_div;
  logic             clk_out;
  logic             clk_en;

  clk_div_ctrl #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .enable  (enable),
    .div_req (div_req),
    .div_val (div_val),
    .div_ack (div_ack),
    .div_err (div_err),
    .busy    (busy),
    .cur_div (cur_div),
    .clk_out (clk_out),
    .clk_en  (clk_en)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int pos      = -1;   // index within current period, -1 = stopped
  int n        = DEF;  // divisor in effect
  int pend     = -1;   // pending divisor, -1 = none
  bit stopping = 1'b0; // enable was low at the last mid-period edge
  bit m_out, m_en, m_ack, m_err;

  task automatic model_step(input bit rst_n, input bit en, input bit req, input int val);
    bit was_busy;
    bit at_wrap;
    int next_n;
    if (!rst_n) begin
      pos = -1; stopping = 1'b0; n = DEF; pend = -1;
      m_out = 1'b0; m_en = 1'b0; m_ack = 1'b0; m_err = 1'b0;
      return;
    end
    was_busy = (pend >= 0);
    at_wrap  = (pos >= 0) && (pos == n - 1);
    next_n   = n;
    m_ack = 1'b0; m_err = 1'b0; m_en = 1'b0;

    if (was_busy && (at_wrap || pos < 0)) begin
      next_n = pend; pend = -1; m_ack = 1'b1;
    end
    if (req && !was_busy) begin
      if (val < 2)      m_err = 1'b1;
      else if (pos < 0) begin next_n = val; m_ack = 1'b1; end
      else              pend = val;
    end

    if (pos < 0) begin
      if (en) begin pos = 0; stopping = 1'b0; m_out = 1'b1; m_en = 1'b1; end
      else m_out = 1'b0;
    end else if (at_wrap) begin
      if (en && !stopping) begin pos = 0; m_out = 1'b1; m_en = 1'b1; end
      else begin pos = -1; stopping = 1'b0; m_out = 1'b0; end
    end else begin
      pos      = pos + 1;
      m_out    = (pos < (n + 1) / 2);
      stopping = !en;
    end
    n = next_n;
  endtask

  task automatic compare_all();
    check("clk_out", int'(clk_out), int'(m_out));
    check("clk_en",  int'(clk_en),  int'(m_en));
    check("div_ack", int'(div_ack), int'(m_ack));
    check("div_err", int'(div_err), int'(m_err));
    check("busy",    int'(busy),    (pend >= 0) ? 1 : 0);
    check("cur_div", int'(cur_div), n);
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    div_req = 1'b0;
    div_val = '0;

    // Reset state against fixed constants
    repeat (2) begin
      @(posedge clk_in);
      model_step(reset_n, enable, div_req, int'(div_val));
      #1;
    end
    check("rst_clk_out", int'(clk_out), 0);
    check("rst_busy",    int'(busy),    0);
    check("rst_cur_div", int'(cur_div), DEF);
    check("rst_ack",     int'(div_ack), 0);

    reset_n = 1'b1;
    enable  = 1'b1;

    // Default divide-by-2: 1,0,1,0 starting one cycle after enable is sampled
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_in);
      model_step(reset_n, enable, div_req, int'(div_val));
      #1;
      check("div2_out", int'(clk_out), (i % 2 == 0) ? 1 : 0);
      check("div2_en",  int'(clk_en),  (i % 2 == 0) ? 1 : 0);
    end

    for (int cyc = 0; cyc < 6000; cyc++) begin
      reset_n = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      div_req = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 39) == 0) div_val = CNT_W'($urandom_range(10, 30));
      else                            div_val = CNT_W'($urandom_range(0, 9));
      @(posedge clk_in);
      model_step(reset_n, enable, div_req, int'(div_val));
      #1;
      compare_all();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
